// File: rtl/vending_coin_collector_if.sv
// Coin-slot/keypad/core bundle around the coin collector; the slave modport is the collector's side.
interface vending_coin_collector_if;
    logic       coinValid;
    logic [1:0] coinType;
    logic       itemSelValid;
    logic [1:0] itemSel;
    logic       cancel;
    logic [1:0] serviceTypeIn;
    logic [1:0] coinOutNTD_50;
    logic [1:0] coinOutNTD_10;
    logic [1:0] coinOutNTD_5;
    logic [1:0] coinOutNTD_1;
    logic [1:0] itemTypeOut;
    logic       refundValid;
    logic [1:0] refundNTD_50;
    logic [1:0] refundNTD_10;
    logic [1:0] refundNTD_5;
    logic [1:0] refundNTD_1;
    logic       coinReject;
    logic [7:0] totalValue;
    logic       busy;

    modport master (
        output coinValid, coinType, itemSelValid, itemSel, cancel, serviceTypeIn,
        input  coinOutNTD_50, coinOutNTD_10, coinOutNTD_5, coinOutNTD_1, itemTypeOut,
        input  refundValid, refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1,
        input  coinReject, totalValue, busy
    );

    modport slave (
        input  coinValid, coinType, itemSelValid, itemSel, cancel, serviceTypeIn,
        output coinOutNTD_50, coinOutNTD_10, coinOutNTD_5, coinOutNTD_1, itemTypeOut,
        output refundValid, refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1,
        output coinReject, totalValue, busy
    );
endinterface

// File: rtl/vending_coin_collector.sv
// Coin collector: counts coins, bundles them with an item for the core; all outputs registered (1-cycle).
// Request held in SEND until the core reports ON; COLLECT_TIMEOUT_EN adds an inactivity auto-refund.
module vending_coin_collector #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMR_W          = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    vending_coin_collector_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_REFUND  = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [3:0][1:0] cnt_q, cnt_d;     // index = coinType code (0 = NTD_50)
    logic            coin_ok, sel_ok, svc_on, svc_off;

    logic [3:0][1:0] co_q, co_d, rf_q, rf_d;
    logic [1:0]      it_q, it_d;
    logic            rv_q, rv_d, rj_q, rj_d, busy_q, busy_d;
    logic [7:0]      tv_q, tv_d;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMR_W)) begin : g_cfg_err
        $error("TIMEOUT_CYCLES must fit in TMR_W bits");
    end

    // Cancel in COLLECT wins over a same-cycle coin, so that coin bounces.
    assign coin_ok = bus.coinValid && (cnt_q[bus.coinType] != 2'd3) &&
                     ((state == S_IDLE) || ((state == S_COLLECT) && !bus.cancel));
    assign sel_ok  = bus.itemSelValid && (bus.itemSel != 2'b00);
    assign svc_on  = (bus.serviceTypeIn == 2'b01);
    assign svc_off = (bus.serviceTypeIn == 2'b00);

`ifdef COLLECT_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmr_hit;

    assign tmr_hit = (tmr_q == TMR_W'(TIMEOUT_CYCLES));

    always_comb begin
        tmr_d = '0;
        if ((state == S_COLLECT) && (state_d == S_COLLECT) && !coin_ok)
            tmr_d = tmr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmr_q <= '0;
        else        tmr_q <= tmr_d;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        if (coin_ok)
            cnt_d[bus.coinType] = cnt_q[bus.coinType] + 2'd1;
        case (state)
            S_IDLE:    if (coin_ok) state_d = S_COLLECT;
            S_COLLECT: begin
                if (bus.cancel)  state_d = S_REFUND;
                else if (sel_ok) state_d = S_SEND;
`ifdef COLLECT_TIMEOUT_EN
                else if (!coin_ok && tmr_hit) state_d = S_REFUND;
`endif
            end
            S_REFUND: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            S_SEND: if (svc_on) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT:  if (svc_off) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from next state/counts so they line up with the state they describe.
    always_comb begin
        co_d   = (state_d == S_SEND) ? cnt_d : '0;
        it_d   = 2'b00;
        if (state_d == S_SEND)
            it_d = (state == S_SEND) ? it_q : bus.itemSel;
        rv_d   = (state_d == S_REFUND);
        rf_d   = rv_d ? cnt_d : '0;
        rj_d   = bus.coinValid && !coin_ok;
        busy_d = (state_d == S_SEND) || (state_d == S_WAIT);
        tv_d   = 8'd50 * {6'd0, cnt_d[0]} + 8'd10 * {6'd0, cnt_d[1]} +
                 8'd5  * {6'd0, cnt_d[2]} + {6'd0, cnt_d[3]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            co_q   <= '0;
            it_q   <= 2'b00;
            rv_q   <= 1'b0;
            rf_q   <= '0;
            rj_q   <= 1'b0;
            busy_q <= 1'b0;
            tv_q   <= 8'd0;
        end else begin
            co_q   <= co_d;
            it_q   <= it_d;
            rv_q   <= rv_d;
            rf_q   <= rf_d;
            rj_q   <= rj_d;
            busy_q <= busy_d;
            tv_q   <= tv_d;
        end
    end

    assign bus.coinOutNTD_50 = co_q[0];
    assign bus.coinOutNTD_10 = co_q[1];
    assign bus.coinOutNTD_5  = co_q[2];
    assign bus.coinOutNTD_1  = co_q[3];
    assign bus.itemTypeOut   = it_q;
    assign bus.refundValid   = rv_q;
    assign bus.refundNTD_50  = rf_q[0];
    assign bus.refundNTD_10  = rf_q[1];
    assign bus.refundNTD_5   = rf_q[2];
    assign bus.refundNTD_1   = rf_q[3];
    assign bus.coinReject    = rj_q;
    assign bus.totalValue    = tv_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_vending_coin_collector.sv
// Directed vector bench for vending_coin_collector, plus timeout and mid-SEND reset sequences.
module tb_vending_coin_collector;

    localparam logic [1:0] C50 = 2'd0, C10 = 2'd1, C5 = 2'd2, C1 = 2'd3;
    localparam logic [1:0] OFF = 2'd0, ON = 2'd1, BSY = 2'd2, SV3 = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vending_coin_collector_if bus();

    vending_coin_collector #(.TIMEOUT_CYCLES(4), .TMR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected bundle: {coinOut 50/10/5/1, item, refundValid, refund 50/10/5/1, coinReject, totalValue, busy}
    typedef struct {
        string       nm;
        logic        cv;
        logic [1:0]  ct;
        logic        sv;
        logic [1:0]  is;
        logic        cn;
        logic [1:0]  svc;
        logic [28:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [28:0] pk(logic [7:0] co, logic [1:0] it, logic rv,
                                       logic [7:0] rf, logic rj, logic [7:0] tv, logic bz);
        return {co, it, rv, rf, rj, tv, bz};
    endfunction

    function automatic logic [28:0] act();
        return {bus.coinOutNTD_50, bus.coinOutNTD_10, bus.coinOutNTD_5, bus.coinOutNTD_1,
                bus.itemTypeOut, bus.refundValid,
                bus.refundNTD_50, bus.refundNTD_10, bus.refundNTD_5, bus.refundNTD_1,
                bus.coinReject, bus.totalValue, bus.busy};
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic add(input string nm, input logic cv, input logic [1:0] ct, input logic sv,
                       input logic [1:0] is, input logic cn, input logic [1:0] svc,
                       input logic [28:0] exp);
        vec_t v;
        v.nm = nm; v.cv = cv; v.ct = ct; v.sv = sv; v.is = is; v.cn = cn; v.svc = svc; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic drive(input logic cv, input logic [1:0] ct, input logic sv,
                         input logic [1:0] is, input logic cn, input logic [1:0] svc);
        bus.coinValid     = cv;
        bus.coinType      = ct;
        bus.itemSelValid  = sv;
        bus.itemSel       = is;
        bus.cancel        = cn;
        bus.serviceTypeIn = svc;
    endtask

    task automatic step(input logic cv, input logic [1:0] ct, input logic sv,
                        input logic [1:0] is, input logic cn, input logic [1:0] svc);
        @(negedge clk);
        drive(cv, ct, sv, is, cn, svc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;

        drive(0, 0, 0, 0, 0, OFF);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", act(), 29'd0);
        @(negedge clk);
        reset = 1'b1;

        add("c50",     1, C50, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 50, 0));
        add("c10",     1, C10, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 60, 0));
        add("c1a",     1, C1,  0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 61, 0));
        add("c1b",     1, C1,  0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 62, 0));
        add("selA",    0, 0,   1, 1, 0, ON,  pk(8'b01_01_00_10, 1, 0, 0, 0, 62, 1));
        add("takeA",   0, 0,   0, 0, 0, ON,  pk(0, 0, 0, 0, 0, 0, 1));
        add("waitA1",  0, 0,   0, 0, 0, BSY, pk(0, 0, 0, 0, 0, 0, 1));
        add("waitA2",  0, 0,   0, 0, 0, BSY, pk(0, 0, 0, 0, 0, 0, 1));
        add("offA",    0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 0, 0));
        add("n5a",     1, C5,  0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 5, 0));
        add("n5b",     1, C5,  0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 10, 0));
        add("n5c",     1, C5,  0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 15, 0));
        add("n5sat",   1, C5,  0, 0, 0, OFF, pk(0, 0, 0, 0, 1, 15, 0));
        add("n5hold",  0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 15, 0));
        add("can5",    0, 0,   0, 0, 1, OFF, pk(0, 0, 1, 8'b00_00_11_00, 0, 15, 0));
        add("ref5",    0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 0, 0));
        add("t10a",    1, C10, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 10, 0));
        add("t10b",    1, C10, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 20, 0));
        add("can10",   1, C1,  0, 0, 1, OFF, pk(0, 0, 1, 8'b00_10_00_00, 1, 20, 0));
        add("ref10",   0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 0, 0));
        add("idleign", 0, 0,   1, 3, 1, OFF, pk(0, 0, 0, 0, 0, 0, 0));
        add("c50b",    1, C50, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 50, 0));
        add("selC",    0, 0,   1, 3, 0, BSY, pk(8'b01_00_00_00, 3, 0, 0, 0, 50, 1));
        add("holdC1",  0, 0,   0, 0, 0, BSY, pk(8'b01_00_00_00, 3, 0, 0, 0, 50, 1));
        add("holdC2",  1, C10, 0, 0, 1, BSY, pk(8'b01_00_00_00, 3, 0, 0, 1, 50, 1));
        add("holdC3",  0, 0,   0, 0, 0, SV3, pk(8'b01_00_00_00, 3, 0, 0, 0, 50, 1));
        add("holdC4",  0, 0,   0, 0, 0, BSY, pk(8'b01_00_00_00, 3, 0, 0, 0, 50, 1));
        add("takeC",   0, 0,   0, 0, 0, ON,  pk(0, 0, 0, 0, 0, 0, 1));
        add("waitOn",  1, C1,  0, 0, 0, ON,  pk(0, 0, 0, 0, 1, 0, 1));
        add("wait3",   0, 0,   0, 0, 0, SV3, pk(0, 0, 0, 0, 0, 0, 1));
        add("offC",    0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 0, 0));
        add("c50c",    1, C50, 0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 50, 0));
        add("selNone", 0, 0,   1, 0, 0, OFF, pk(0, 0, 0, 0, 0, 50, 0));
        add("c1selB",  1, C1,  1, 2, 0, OFF, pk(8'b01_00_00_01, 2, 0, 0, 0, 51, 1));
        add("takeB",   0, 0,   0, 0, 0, ON,  pk(0, 0, 0, 0, 0, 0, 1));
        add("offB",    0, 0,   0, 0, 0, OFF, pk(0, 0, 0, 0, 0, 0, 0));

        foreach (vq[i]) begin
            step(vq[i].cv, vq[i].ct, vq[i].sv, vq[i].is, vq[i].cn, vq[i].svc);
            check(vq[i].nm, act(), vq[i].exp);
        end

        // Inactivity in COLLECT: auto-refund only when the timeout feature is built in.
        step(1, C50, 0, 0, 0, OFF);
        check("to_coin", bus.totalValue, 8'd50);
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(0, 0, 0, 0, 0, OFF);
            if (bus.refundValid) begin
                seen = 1'b1;
                n = k;
                check("to_refund", {bus.refundNTD_50, bus.refundNTD_10, bus.refundNTD_5, bus.refundNTD_1},
                      8'b01_00_00_00);
            end
        end
`ifdef COLLECT_TIMEOUT_EN
        check("to_latency", n, 5);
`else
        check("no_timeout", {31'd0, seen}, 32'd0);
        step(0, 0, 0, 0, 1, OFF);
        check("to_cancel", bus.refundValid, 1'b1);
`endif
        step(0, 0, 0, 0, 0, OFF);
        check("to_idle", act(), 29'd0);

        // Reset while the request is on the bus drops everything at once.
        step(1, C50, 0, 0, 0, OFF);
        step(0, 0, 1, 1, 0, BSY);
        check("rst_pre", act(), pk(8'b01_00_00_00, 1, 0, 0, 0, 50, 1));
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("rst_async", act(), 29'd0);
        @(posedge clk);
        #1 check("rst_norefund", bus.refundValid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1, C10, 0, 0, 0, OFF);
        check("post_rst", act(), pk(0, 0, 0, 0, 0, 10, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_coin_collector.md
Name: vending_coin_collector

Overview:
- Upstream front-end for the vending machine core. Accepts one coin per cycle from the coin slot and one item selection from the keypad.
- Accumulates per-denomination coin counts and presents them to the core as a single bundled request (coin counts plus item type).
- The request is presented only while the core reports SERVICE_ON; the collector then waits for the transaction to finish.
- Also supports customer cancel/refund and rejection of coins it cannot hold.

Parameters:
- TIMEOUT_CYCLES, 255: idle cycles in COLLECT before automatic refund (used only with the optional feature).
- TMR_W, 8: width of the inactivity timer; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- coinValid, input, 1: one coin presented this cycle.
- coinType, input, 2: coin denomination. 00 = NTD_50, 01 = NTD_10, 10 = NTD_5, 11 = NTD_1.
- itemSelValid, input, 1: item selection presented this cycle.
- itemSel, input, 2: item code. 00 = NONE, 01 = A, 10 = B, 11 = C.
- cancel, input, 1: customer cancel request.
- serviceTypeIn, input, 2: core service state. 00 = OFF, 01 = ON, 10 = BUSY.
- coinOutNTD_50, output, 2: NTD_50 count to the core.
- coinOutNTD_10, output, 2: NTD_10 count to the core.
- coinOutNTD_5, output, 2: NTD_5 count to the core.
- coinOutNTD_1, output, 2: NTD_1 count to the core.
- itemTypeOut, output, 2: item request to the core.
- refundValid, output, 1: one-cycle pulse; refund counts are valid in that cycle.
- refundNTD_50, output, 2: NTD_50 coins returned to the customer.
- refundNTD_10, output, 2: NTD_10 coins returned to the customer.
- refundNTD_5, output, 2: NTD_5 coins returned to the customer.
- refundNTD_1, output, 2: NTD_1 coins returned to the customer.
- coinReject, output, 1: one-cycle pulse; the coin from the previous cycle was returned.
- totalValue, output, 8: value currently held, = 50*n50 + 10*n10 + 5*n5 + n1. Maximum 198, so no overflow.
- busy, output, 1: high in SEND and WAIT.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, all held counts = 0, timer = 0. All outputs are 0, so itemTypeOut = NONE. Reset asserted mid-transaction discards held coins with no refund pulse.
- All outputs are registered.
- Held counts: four 2-bit counters, one per denomination. A counter saturates at 3.
- Coin acceptance:
  - A coin is accepted only in IDLE or COLLECT, and only if its counter is below 3.
  - Otherwise the coin is rejected: coinReject = 1 in the following cycle and counts are unchanged.
  - An accepted coin increments its counter on the same edge.
- IDLE:
  - Accepted coin -> COLLECT.
  - itemSelValid and cancel are ignored.
- COLLECT:
  - cancel -> REFUND. Cancel has priority over a same-cycle coin (coin rejected) and over a same-cycle selection (selection ignored).
  - Else itemSelValid with itemSel != NONE: latch itemSel -> SEND. A same-cycle accepted coin is included in the bundle.
  - itemSelValid with itemSel = NONE is ignored.
  - Accepted coin: stay in COLLECT.
- REFUND:
  - For one cycle: refundValid = 1 and refundNTD_* = held counts.
  - Then clear the counts and return to IDLE.
  - totalValue reads 0 from the cycle after REFUND.
- SEND:
  - coinOutNTD_* = held counts and itemTypeOut = latched item, held stable.
  - On an edge where serviceTypeIn = ON the core consumes the request. Next state is WAIT; coinOut and itemTypeOut go to 0/NONE and counts clear.
  - While serviceTypeIn != ON, remain in SEND.
  - cancel and coins in SEND are ignored and rejected respectively.
- WAIT:
  - Coins are rejected.
  - Leave for IDLE on the first edge with serviceTypeIn = OFF (the core is returning change).
  - serviceTypeIn = 11 is treated as BUSY.
- Request presentation: itemTypeOut != NONE only in SEND. The core therefore sees exactly one sampling edge per transaction.
- Timer: cleared on every accepted coin and on entering COLLECT. It increments each cycle in COLLECT and otherwise holds 0.

Optional Feature:
- Macro: COLLECT_TIMEOUT_EN.
- Defined:
  - When the timer reaches TIMEOUT_CYCLES in COLLECT with no cancel, selection or accepted coin that cycle, go to REFUND (automatic refund).
  - A same-cycle accepted coin restarts the timer instead.
- Undefined:
  - COLLECT waits indefinitely.
  - The timer register and compare logic are absent.
  - TIMEOUT_CYCLES and TMR_W have no effect.

Test Plan:
- Reset, then insert coins 50, 10, 1, 1, then select item A with serviceTypeIn = ON -> SEND for 1 cycle with coinOut = 1/1/0/2 and itemTypeOut = 01, totalValue = 62. Then WAIT; with serviceTypeIn = BUSY, BUSY, OFF -> IDLE, and all outputs return to 0.
- Insert NTD_5 four times -> counts 0/0/3/0, coinReject pulses once after the 4th coin, totalValue = 15.
- Insert 10 and 10, then cancel -> refundValid 1 cycle with refundNTD_10 = 2, then IDLE with totalValue = 0. Same-cycle coin is rejected.
- Select C while serviceTypeIn = BUSY -> stays in SEND holding itemTypeOut = 11 for 5 cycles. Transfer completes on the first edge with serviceTypeIn = ON.
- Coin NTD_1 and select B in the same cycle from COLLECT holding one 50 -> bundle 1/0/0/1 with itemTypeOut = 10.
- COLLECT_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4: insert one 50 and wait -> refundValid with refundNTD_50 = 1. Assert reset mid-SEND -> outputs are 0 immediately and no refund pulse.
